instruction_control_unit: RTL and testbench
===========================================

# instruction_control_unit

Multi-cycle control FSM for the 8-bit accumulator processor. It fetches instructions from a 32-word synchronous RAM, holds the instruction word, and sequences the accumulator datapath. It sits directly upstream of the instruction-set datapath: it drives the datapath's `Asel`, `loadA`, `clearA` and `sub` inputs, and consumes its `Aeq0` and `Apos` flags. It also drives the operand-register load that feeds the datapath's `IROut` bus, and owns the program counter.

## Interface
Parameters:
- `n`, 8, instruction/data word width; opcode is `instr[n-1:n-3]`, address is `instr[n-4:0]` (5 bits at n=8)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ramData`  in  n  RAM read data, valid one cycle after `memAddr`
- `enter`  in  1  operator "input ready" level from the front panel
- `Aeq0`  in  1  datapath flag: A == 0
- `Apos`  in  1  datapath flag: A[7] == 0
- `memAddr`  out  n-3  RAM address
- `memWrite`  out  1  RAM write strobe; RAM writes A at `memAddr`
- `opLoad`  out  1  operand register latches `ramData`; drives datapath `IROut`
- `Asel`  out  2  datapath mux select: 0 = SubOut, 1 = Input, 2 = IROut, 3 = GND
- `loadA`, `clearA`, `sub`  out  1 each  datapath controls
- `pc`  out  n-3  program counter
- `waitIn`  out  1  high while waiting for `enter`
- `halt`  out  1  high in HALT

## Operation
- Opcodes:
  - 000 LOAD: A <- M[a]
  - 001 STORE: M[a] <- A
  - 010 ADD: A <- A + M[a]
  - 011 SUB: A <- A - M[a]
  - 100 IN: A <- Input
  - 101 JZ: if A == 0, PC <- a
  - 110 JPOS: if A >= 0, PC <- a
  - 111 HALT
- States:
  - INIT: `clearA`=1 for one cycle, then FETCH.
  - FETCH: `memAddr`=pc, then LATCH.
  - LATCH: instr <= ramData; pc <= pc+1; then DECODE.
  - DECODE: `memAddr`=instr address. Next state by opcode:
    - LOAD/ADD/SUB -> OPLOAD.
    - STORE: `memWrite`=1, then FETCH.
    - JZ/JPOS: sample the flag this cycle; if taken, pc <= a; then FETCH.
    - IN -> INWAIT.
    - HALT -> HALT.
  - OPLOAD: `memAddr`=instr address, `opLoad`=1, then EXEC.
  - EXEC: `loadA`=1. `Asel`=2 for LOAD; `Asel`=0 for ADD/SUB. `sub`=1 only for SUB. Then FETCH.
  - INWAIT: `waitIn`=1. On `enter`=1: `Asel`=1, `loadA`=1, go to INREL. Otherwise stay.
  - INREL: `waitIn`=1. Stay while `enter`=1; go to FETCH when `enter`=0, so one press loads exactly once.
  - HALT: `halt`=1. Held until reset.
- All strobes are Moore outputs decoded from state and instr. Only DECODE also uses `Aeq0`/`Apos`.
- Defaults when not asserted: `Asel`=3, `memAddr`=pc.
- pc is modulo 2^(n-3): 31+1 wraps to 0.

## Timing
- Reset (asynchronous, on `reset_n`=0): state=INIT, pc=0, instr=0.
  - While in reset: all strobes 0, `Asel`=3, `memAddr`=0.
  - `clearA` rises in the first cycle after release.
- Cycles per instruction:
  - LOAD/ADD/SUB: 5 (FETCH, LATCH, DECODE, OPLOAD, EXEC).
  - STORE, JZ, JPOS: 3.
  - IN: 3 + wait + release.
- New A is visible to the flags the cycle after EXEC or the INWAIT accept.
  - A following JZ/JPOS therefore sees it: its DECODE is 3 cycles later.
- `enter` already high on entry to INWAIT: accepted in the first INWAIT cycle.
- Reset asserted mid-instruction aborts immediately:
  - No partial `memWrite` or `loadA` after reset asserts.
  - Execution restarts at INIT / pc=0.
- Jump to the current address (a tight loop) is legal. pc is updated in DECODE, overriding the LATCH increment.

## Structure
- Shared package `isa_pkg`: opcode localparams (OP_LOAD ... OP_HALT), `Asel` codes (SEL_SUB=0, SEL_IN=1, SEL_IR=2, SEL_GND=3), state encoding.
- One sub-module: `program_counter`. It holds pc with async clear, increment enable and parallel load; load has priority over increment.
- FSM state register and output decode stay in `instruction_control_unit`.

## Test plan
- Reset, then release with RAM[0]=111_00000 -> exactly one INIT cycle with `clearA`=1, then `halt`=1 by cycle 4; pc=1.
- RAM: 0 = LOAD 10, 1 = ADD 11, 2 = STORE 12, 3 = HALT; M10=5, M11=3 -> `memWrite` at addr 12 with A=8; `sub`=0 throughout; HALT reached in 5+5+3+3 cycles.
- SUB with A=3, M=5, then JPOS 0 -> `sub`=1 in EXEC; `Apos`=0, so not taken; pc continues to 4.
- IN with `enter` held high for 4 cycles -> exactly one `loadA` with `Asel`=1; FSM stays in INREL until `enter` falls.
- JZ 31 with A=0, then an instruction at 31 executes -> pc wraps to 0 after the LATCH of address 31.
- `reset_n` pulsed low during OPLOAD of a LOAD -> no `loadA`; pc=0; INIT re-entered with `clearA`=1.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared definitions for the 8-bit accumulator processor: opcodes,
// datapath mux select codes and the control FSM state encoding.
package isa_pkg;

  // Opcodes live in the top three bits of the instruction word.
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Datapath A-register input mux codes.
  localparam logic [1:0] SEL_SUB = 2'd0;
  localparam logic [1:0] SEL_IN  = 2'd1;
  localparam logic [1:0] SEL_IR  = 2'd2;
  localparam logic [1:0] SEL_GND = 2'd3;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_LATCH  = 4'd2,
    ST_DECODE = 4'd3,
    ST_OPLOAD = 4'd4,
    ST_EXEC   = 4'd5,
    ST_INWAIT = 4'd6,
    ST_INREL  = 4'd7,
    ST_HALT   = 4'd8
  } state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: async clear, increment enable and parallel load.
// Load wins over increment so a jump in DECODE overrides any increment.
module program_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] pc
);

  // pc register; increment wraps naturally modulo 2^W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_control_unit.sv
// Multi-cycle control FSM for the accumulator processor: fetches from a
// synchronous RAM, holds the instruction word and sequences the datapath.
module instruction_control_unit
  import isa_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] ramData,
  input  logic         enter,
  input  logic         Aeq0,
  input  logic         Apos,
  output logic [n-4:0] memAddr,
  output logic         memWrite,
  output logic         opLoad,
  output logic [1:0]   Asel,
  output logic         loadA,
  output logic         clearA,
  output logic         sub,
  output logic [n-4:0] pc,
  output logic         waitIn,
  output logic         halt
);

  state_t       state;
  logic [n-1:0] instr;
  logic [2:0]   opcode;
  logic [n-4:0] operand_addr;
  logic         pc_inc;
  logic         jump_taken;

  assign opcode       = instr[n-1:n-3];
  assign operand_addr = instr[n-4:0];

  // Branch condition is sampled only while decoding a JZ/JPOS.
  assign jump_taken = (state == ST_DECODE) &&
                      (((opcode == OP_JZ) && Aeq0) ||
                       ((opcode == OP_JPOS) && Apos));
  assign pc_inc     = (state == ST_LATCH);

  program_counter #(
    .W(n-3)
  ) u_pc (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc        (pc_inc),
    .load       (jump_taken),
    .load_value (operand_addr),
    .pc         (pc)
  );

  // State register and instruction latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      instr <= '0;
    end else begin
      case (state)
        ST_INIT:  state <= ST_FETCH;
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          instr <= ramData;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          case (opcode)
            OP_LOAD, OP_ADD, OP_SUB: state <= ST_OPLOAD;
            OP_IN:                   state <= ST_INWAIT;
            OP_HALT:                 state <= ST_HALT;
            default:                 state <= ST_FETCH;
          endcase
        end
        ST_OPLOAD: state <= ST_EXEC;
        ST_EXEC:   state <= ST_FETCH;
        ST_INWAIT: if (enter) state <= ST_INREL;
        ST_INREL:  if (!enter) state <= ST_FETCH;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_INIT;
      endcase
    end
  end

  // Strobe decode from state and instruction. Everything is forced idle
  // while reset_n is low so an aborted instruction leaves no partial
  // write or load, and clearA only appears once reset is released.
  always_comb begin
    memAddr  = pc;
    memWrite = 1'b0;
    opLoad   = 1'b0;
    Asel     = SEL_GND;
    loadA    = 1'b0;
    clearA   = 1'b0;
    sub      = 1'b0;
    waitIn   = 1'b0;
    halt     = 1'b0;
    if (reset_n) begin
      case (state)
        ST_INIT: clearA = 1'b1;
        ST_DECODE: begin
          memAddr  = operand_addr;
          memWrite = (opcode == OP_STORE);
        end
        ST_OPLOAD: begin
          memAddr = operand_addr;
          opLoad  = 1'b1;
        end
        ST_EXEC: begin
          loadA = 1'b1;
          Asel  = (opcode == OP_LOAD) ? SEL_IR : SEL_SUB;
          sub   = (opcode == OP_SUB);
        end
        ST_INWAIT: begin
          waitIn = 1'b1;
          if (enter) begin
            Asel  = SEL_IN;
            loadA = 1'b1;
          end
        end
        ST_INREL: waitIn = 1'b1;
        ST_HALT:  halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_control_unit.sv
// Directed bench for instruction_control_unit with a behavioural RAM and
// accumulator datapath around it.
module tb_instruction_control_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ramData;
  logic       enter;
  logic       Aeq0, Apos;
  logic [4:0] memAddr;
  logic       memWrite, opLoad, loadA, clearA, sub, waitIn, halt;
  logic [1:0] Asel;
  logic [4:0] pc;

  logic [7:0] mem [32];
  logic [7:0] prog [32];
  logic [7:0] acc = 8'h00;
  logic [7:0] ir_q = 8'h00;
  logic [7:0] in_val;

  int vec_cnt = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_control_unit #(.n(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ramData  (ramData),
    .enter    (enter),
    .Aeq0     (Aeq0),
    .Apos     (Apos),
    .memAddr  (memAddr),
    .memWrite (memWrite),
    .opLoad   (opLoad),
    .Asel     (Asel),
    .loadA    (loadA),
    .clearA   (clearA),
    .sub      (sub),
    .pc       (pc),
    .waitIn   (waitIn),
    .halt     (halt)
  );

  // Synchronous RAM; the program image is copied in while reset is held.
  always @(posedge clk) begin
    if (!reset_n) mem <= prog;
    else if (memWrite) mem[memAddr] <= acc;
    ramData <= mem[memAddr];
  end

  // Accumulator datapath model.
  always @(posedge clk) begin
    if (opLoad) ir_q <= ramData;
    if (clearA) acc <= 8'h00;
    else if (loadA) begin
      case (Asel)
        2'd0:    acc <= sub ? acc - ir_q : acc + ir_q;
        2'd1:    acc <= in_val;
        2'd2:    acc <= ir_q;
        default: acc <= 8'h00;
      endcase
    end
  end

  assign Aeq0 = (acc == 8'h00);
  assign Apos = ~acc[7];

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask

  // Holds reset for two cycles, releases at a negedge; returns in cycle 0 (INIT).
  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = 8'hE0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (clearA !== 1'b0) begin miscompares++; $display("FAIL reset_clearA got=%b want=0", clearA); end
    vec_cnt++; if (Asel !== 2'd3) begin miscompares++; $display("FAIL reset_Asel got=%0d want=3", Asel); end
    vec_cnt++; if (memAddr !== 5'd0) begin miscompares++; $display("FAIL reset_memAddr got=%0d want=0", memAddr); end
    vec_cnt++; if ({memWrite, opLoad, loadA, sub, waitIn, halt} !== 6'b0) begin miscompares++; $display("FAIL reset_strobes got=%b want=000000", {memWrite, opLoad, loadA, sub, waitIn, halt}); end
    vec_cnt++; if (pc !== 5'd0) begin miscompares++; $display("FAIL reset_pc got=%0d want=0", pc); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vec_cnt++; if (clearA !== 1'b1) begin miscompares++; $display("FAIL init_clearA got=%b want=1", clearA); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      vec_cnt++; if (clearA !== 1'b0) begin miscompares++; $display("FAIL clearA_once cyc=%0d got=%b want=0", c, clearA); end
      if (c == 3) begin
        vec_cnt++; if (halt !== 1'b0) begin miscompares++; $display("FAIL halt_early got=%b want=0", halt); end
      end
    end
    vec_cnt++; if (halt !== 1'b1) begin miscompares++; $display("FAIL halt_cyc4 got=%b want=1", halt); end
    vec_cnt++; if (pc !== 5'd1) begin miscompares++; $display("FAIL halt_pc got=%0d want=1", pc); end
    $display("test_reset done: halt=%b pc=%0d", halt, pc);
  endtask

  task automatic test_load_add_store();
    int halt_cyc, loads, writes, wa, wd, sub_cnt;
    int lc [2];
    logic [1:0] ls [2];
    clear_prog();
    prog[0] = 8'h0A; prog[1] = 8'h4B; prog[2] = 8'h2C; prog[3] = 8'hE0;
    prog[10] = 8'd5; prog[11] = 8'd3;
    halt_cyc = -1; loads = 0; writes = 0; wa = -1; wd = -1; sub_cnt = 0;
    lc[0] = -1; lc[1] = -1; ls[0] = 2'd3; ls[1] = 2'd3;
    apply_reset();
    for (int c = 1; c <= 60 && halt_cyc < 0; c++) begin
      @(negedge clk); #1;
      if (loadA) begin
        if (loads < 2) begin lc[loads] = c; ls[loads] = Asel; end
        loads++;
      end
      if (memWrite) begin writes++; wa = int'(memAddr); wd = int'(acc); end
      if (sub) sub_cnt++;
      if (halt) halt_cyc = c;
    end
    vec_cnt++; if (halt_cyc != 17) begin miscompares++; $display("FAIL las_halt_cycle got=%0d want=17", halt_cyc); end
    vec_cnt++; if (loads != 2) begin miscompares++; $display("FAIL las_load_count got=%0d want=2", loads); end
    vec_cnt++; if (lc[0] != 5 || ls[0] !== 2'd2) begin miscompares++; $display("FAIL las_load_exec got=cyc%0d/sel%0d want=cyc5/sel2", lc[0], ls[0]); end
    vec_cnt++; if (lc[1] != 10 || ls[1] !== 2'd0) begin miscompares++; $display("FAIL las_add_exec got=cyc%0d/sel%0d want=cyc10/sel0", lc[1], ls[1]); end
    vec_cnt++; if (writes != 1 || wa != 12 || wd != 8) begin miscompares++; $display("FAIL las_store got=n%0d@%0d=%0d want=n1@12=8", writes, wa, wd); end
    vec_cnt++; if (sub_cnt != 0) begin miscompares++; $display("FAIL las_sub got=%0d want=0", sub_cnt); end
    vec_cnt++; if (mem[12] !== 8'd8) begin miscompares++; $display("FAIL las_mem12 got=%0d want=8", mem[12]); end
    vec_cnt++; if (pc !== 5'd4) begin miscompares++; $display("FAIL las_pc got=%0d want=4", pc); end
    $display("test_load_add_store done: A=%0d halt_cyc=%0d", acc, halt_cyc);
  endtask

  task automatic test_sub_jpos();
    int halt_cyc, sub_cnt, sub_cyc, fetch_addr;
    clear_prog();
    prog[0] = 8'h0A; prog[1] = 8'h6B; prog[2] = 8'hC0; prog[3] = 8'hE0;
    prog[10] = 8'd3; prog[11] = 8'd5;
    halt_cyc = -1; sub_cnt = 0; sub_cyc = -1; fetch_addr = -1;
    apply_reset();
    for (int c = 1; c <= 60 && halt_cyc < 0; c++) begin
      @(negedge clk); #1;
      if (sub) begin sub_cnt++; sub_cyc = c; end
      if (c == 14) fetch_addr = int'(memAddr);
      if (halt) halt_cyc = c;
    end
    vec_cnt++; if (sub_cnt != 1 || sub_cyc != 10) begin miscompares++; $display("FAIL sub_strobe got=n%0d@cyc%0d want=n1@cyc10", sub_cnt, sub_cyc); end
    vec_cnt++; if (acc !== 8'hFE) begin miscompares++; $display("FAIL sub_result got=%h want=fe", acc); end
    vec_cnt++; if (fetch_addr != 3) begin miscompares++; $display("FAIL jpos_not_taken_fetch got=%0d want=3", fetch_addr); end
    vec_cnt++; if (halt_cyc != 17) begin miscompares++; $display("FAIL sub_halt_cycle got=%0d want=17", halt_cyc); end
    vec_cnt++; if (pc !== 5'd4) begin miscompares++; $display("FAIL sub_pc got=%0d want=4", pc); end
    $display("test_sub_jpos done: A=%h pc=%0d", acc, pc);
  endtask

  task automatic test_in();
    int halt_cyc, loads, lcyc;
    logic [1:0] lsel;
    logic w4, w8, w9, w10, l4;
    clear_prog();
    prog[0] = 8'h80; prog[1] = 8'hE0;
    in_val = 8'h5A;
    enter = 1'b0;
    halt_cyc = -1; loads = 0; lcyc = -1; lsel = 2'd3;
    w4 = 1'b0; w8 = 1'b0; w9 = 1'b0; w10 = 1'b1; l4 = 1'b1;
    apply_reset();
    for (int c = 1; c <= 40 && halt_cyc < 0; c++) begin
      @(negedge clk);
      enter = (c >= 5 && c <= 8);
      #1;
      if (loadA) begin loads++; lcyc = c; lsel = Asel; end
      if (c == 4) begin w4 = waitIn; l4 = loadA; end
      if (c == 8) w8 = waitIn;
      if (c == 9) w9 = waitIn;
      if (c == 10) w10 = waitIn;
      if (halt) halt_cyc = c;
    end
    enter = 1'b0;
    vec_cnt++; if (w4 !== 1'b1 || l4 !== 1'b0) begin miscompares++; $display("FAIL in_wait got=wait%b/load%b want=wait1/load0", w4, l4); end
    vec_cnt++; if (loads != 1 || lcyc != 5 || lsel !== 2'd1) begin miscompares++; $display("FAIL in_single_load got=n%0d@cyc%0d/sel%0d want=n1@cyc5/sel1", loads, lcyc, lsel); end
    vec_cnt++; if (w8 !== 1'b1 || w9 !== 1'b1) begin miscompares++; $display("FAIL in_release got=%b%b want=11", w8, w9); end
    vec_cnt++; if (w10 !== 1'b0) begin miscompares++; $display("FAIL in_leave got=%b want=0", w10); end
    vec_cnt++; if (acc !== 8'h5A) begin miscompares++; $display("FAIL in_value got=%h want=5a", acc); end
    vec_cnt++; if (halt_cyc != 13) begin miscompares++; $display("FAIL in_halt_cycle got=%0d want=13", halt_cyc); end
    $display("test_in done: A=%h halt_cyc=%0d", acc, halt_cyc);
  endtask

  task automatic test_jz_wrap();
    clear_prog();
    prog[0] = 8'hBF;
    prog[31] = 8'h34;
    apply_reset();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); #1;
      if (c == 3) begin
        vec_cnt++; if (pc !== 5'd1) begin miscompares++; $display("FAIL jz_pc_after_latch got=%0d want=1", pc); end
      end
      if (c == 4) begin
        vec_cnt++; if (pc !== 5'd31 || memAddr !== 5'd31) begin miscompares++; $display("FAIL jz_taken got=pc%0d/addr%0d want=pc31/addr31", pc, memAddr); end
      end
      if (c == 6) begin
        vec_cnt++; if (pc !== 5'd0) begin miscompares++; $display("FAIL pc_wrap got=%0d want=0", pc); end
        vec_cnt++; if (memWrite !== 1'b1 || memAddr !== 5'd20) begin miscompares++; $display("FAIL wrap_store got=we%b@%0d want=we1@20", memWrite, memAddr); end
      end
      if (c == 7) begin
        vec_cnt++; if (memAddr !== 5'd0) begin miscompares++; $display("FAIL wrap_fetch got=%0d want=0", memAddr); end
      end
    end
    $display("test_jz_wrap done: pc=%0d", pc);
  endtask

  task automatic test_reset_mid();
    clear_prog();
    prog[0] = 8'h0A; prog[1] = 8'hE0; prog[10] = 8'h77;
    apply_reset();
    repeat (4) @(negedge clk);
    #1;
    vec_cnt++; if (opLoad !== 1'b1) begin miscompares++; $display("FAIL mid_opload got=%b want=1", opLoad); end
    reset_n = 1'b0;
    #1;
    vec_cnt++; if ({loadA, opLoad, memWrite, clearA} !== 4'b0) begin miscompares++; $display("FAIL mid_abort_strobes got=%b want=0000", {loadA, opLoad, memWrite, clearA}); end
    vec_cnt++; if (pc !== 5'd0 || memAddr !== 5'd0) begin miscompares++; $display("FAIL mid_abort_pc got=pc%0d/addr%0d want=0/0", pc, memAddr); end
    @(negedge clk); #1;
    vec_cnt++; if (loadA !== 1'b0 || acc !== 8'h00) begin miscompares++; $display("FAIL mid_no_load got=load%b/A%h want=0/00", loadA, acc); end
    reset_n = 1'b1;
    #1;
    vec_cnt++; if (clearA !== 1'b1) begin miscompares++; $display("FAIL mid_reinit got=%b want=1", clearA); end
    @(negedge clk); #1;
    vec_cnt++; if (clearA !== 1'b0 || memAddr !== 5'd0 || pc !== 5'd0) begin miscompares++; $display("FAIL mid_refetch got=clr%b/addr%0d/pc%0d want=0/0/0", clearA, memAddr, pc); end
    $display("test_reset_mid done: pc=%0d A=%h", pc, acc);
  endtask

  initial begin
    reset_n = 1'b0;
    enter   = 1'b0;
    in_val  = 8'h00;
    clear_prog();
    test_reset();
    test_load_add_store();
    test_sub_jpos();
    test_in();
    test_jz_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
